// File: rtl/md_pkg.sv
// Shared types and constants for the md_ram_arbiter RAM-sharing block.
package md_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } md_arb_state_t;

    function automatic int md_be_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/md_rr_pick.sv
// Combinational request picker: fixed-priority from index 0, or round-robin
// starting at a given index; returns a one-hot grant and its binary index.
module md_rr_pick
    import md_pkg::*;
#(
    parameter int CHANNELS = 2,
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IW-1:0]       start,
    input  logic                mode_rr,
    output logic [CHANNELS-1:0] grant,
    output logic [IW-1:0]       grant_idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = mode_rr ? IW'((int'(start) + i) % CHANNELS) : IW'(i);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/md_ram_arbiter.sv
// Time-shares one single-port synchronous RAM between several masters:
// one granted access per transfer, byte-lane writes, one-cycle ack pulse.
module md_ram_arbiter
    import md_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int AW       = 15,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MODE     = ARB_RR,
    localparam int BE      = md_be_width(DW),
    localparam int IW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   MCLK,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    req,
    input  logic [CHANNELS-1:0]    we,
    input  logic [CHANNELS*AW-1:0] addr,
    input  logic [CHANNELS*DW-1:0] wdata,
    input  logic [CHANNELS*BE-1:0] be,
    output logic [CHANNELS-1:0]    ack,
    output logic [DW-1:0]          rdata,
    output logic [AW-1:0]          ram_addr,
    output logic [DW-1:0]          ram_data,
    output logic [BE-1:0]          ram_byteena,
    output logic                   ram_wren,
    input  logic [DW-1:0]          ram_q
);

    md_arb_state_t state_q, state_d;

    logic [CHANNELS-1:0] grant_q, grant_d, ack_q, ack_d, pick_grant;
    logic [IW-1:0]       last_q, last_d, pick_idx, start;
    logic                we_q, we_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [AW-1:0]       ram_addr_q, ram_addr_d;
    logic [DW-1:0]       ram_data_q, ram_data_d;
    logic [BE-1:0]       ram_be_q, ram_be_d, pick_be;
    logic                ram_wren_q, ram_wren_d;

    assign start   = IW'((int'(last_q) + 1) % CHANNELS);
    assign pick_be = be[int'(pick_idx)*BE +: BE];

    md_rr_pick #(.CHANNELS(CHANNELS)) u_pick (
        .req       (req),
        .start     (start),
        .mode_rr   (1'(MODE == ARB_RR)),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    // The RAM port registers double as the request latches. IDLE ignores req
    // while ack is high, since the requester only updates req on that edge.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_be_d   = ram_be_q;
        ram_wren_d = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|req) && (ack_q == '0)) begin
                    state_d    = ACCESS;
                    grant_d    = pick_grant;
                    last_d     = pick_idx;
                    we_d       = we[pick_idx];
                    ram_addr_d = addr[int'(pick_idx)*AW +: AW];
                    ram_data_d = wdata[int'(pick_idx)*DW +: DW];
                    ram_be_d   = pick_be;
                    ram_wren_d = we[pick_idx] & (|pick_be);
                end
            end
            ACCESS: begin
                state_d = (RD_LAT == 1) ? DONE : WAIT;
                cnt_d   = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ack_d   = grant_q;
                if (!we_q) begin
                    rdata_d = ram_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= IW'(CHANNELS - 1);
            we_q       <= 1'b0;
            cnt_q      <= 2'd0;
            ack_q      <= '0;
            rdata_q    <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_be_q   <= '0;
            ram_wren_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_be_q   <= ram_be_d;
            ram_wren_q <= ram_wren_d;
        end
    end

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data    = ram_data_q;
    assign ram_byteena = ram_be_q;
    assign ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_md_ram_arbiter.sv
// Bench for md_ram_arbiter: instance 0 is round-robin with RD_LAT 1,
// instance 1 is fixed-priority with RD_LAT 3; each has its own RAM model.
module tb_md_ram_arbiter;
    import md_pkg::*;

    localparam int CH  = 3;
    localparam int AW  = 15;
    localparam int DW  = 16;
    localparam int BEW = 2;

    typedef struct {
        logic [CH-1:0] ack;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        int          k;
        int          ch;
        logic        w;
        logic [14:0] a;
        logic [15:0] d;
        logic [1:0]  b;
        logic [15:0] rd;
    } vec_t;

    logic MCLK = 1'b0;
    logic rst [2];
    logic [CH-1:0]     req [2];
    logic [CH-1:0]     we [2];
    logic [CH*AW-1:0]  addr [2];
    logic [CH*DW-1:0]  wdata [2];
    logic [CH*BEW-1:0] be [2];
    logic [CH-1:0]     ack [2];
    logic [DW-1:0]     rdata [2];
    logic [AW-1:0]     ram_addr [2];
    logic [DW-1:0]     ram_data [2];
    logic [BEW-1:0]    ram_be [2];
    logic              ram_wren [2];

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t mon_e;
    vec_t vecs [10];
    int   cnt;

    always #5 MCLK = ~MCLK;

    genvar k;
    generate
        for (k = 0; k < 2; k++) begin : g
            localparam int LAT = (k == 0) ? 1 : 3;
            logic [15:0] mem [0:32767];
            logic [15:0] pipe [0:2];

            initial begin
                for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
                for (int i = 0; i < 3; i++) pipe[i] = 16'h0000;
            end

            // RAM model: address registered on the edge after ACCESS, q valid LAT edges later
            always @(posedge MCLK) begin
                if (ram_wren[k]) begin
                    if (ram_be[k][0]) mem[ram_addr[k]][7:0]  <= ram_data[k][7:0];
                    if (ram_be[k][1]) mem[ram_addr[k]][15:8] <= ram_data[k][15:8];
                end
                pipe[0] <= mem[ram_addr[k]];
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
            end

            md_ram_arbiter #(
                .CHANNELS (CH),
                .AW       (AW),
                .DW       (DW),
                .RD_LAT   (LAT),
                .MODE     ((k == 0) ? ARB_RR : ARB_FIXED)
            ) dut (
                .MCLK        (MCLK),
                .reset       (rst[k]),
                .req         (req[k]),
                .we          (we[k]),
                .addr        (addr[k]),
                .wdata       (wdata[k]),
                .be          (be[k]),
                .ack         (ack[k]),
                .rdata       (rdata[k]),
                .ram_addr    (ram_addr[k]),
                .ram_data    (ram_data[k]),
                .ram_byteena (ram_be[k]),
                .ram_wren    (ram_wren[k]),
                .ram_q       (pipe[LAT-1])
            );
        end
    endgenerate

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req_v);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected completion for that instance
    always @(negedge MCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (ack[i] != '0) begin
                if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_ack inst%0d: got %b, required none", i, ack[i]);
                end else begin
                    if (i == 0) mon_e = exp_q0.pop_front();
                    else        mon_e = exp_q1.pop_front();
                    checkOutput($sformatf("ack_inst%0d", i), 32'(ack[i]), 32'(mon_e.ack));
                    checkOutput($sformatf("rdata_inst%0d", i), 32'(rdata[i]), 32'(mon_e.rdata));
                end
            end
        end
    end

    task automatic applyStimulus(input int ki, input int ch, input logic w, input logic [14:0] a,
                                 input logic [15:0] d, input logic [1:0] b, input logic [15:0] rd);
        exp_t e;
        int   lat;
        bit   seen;
        lat     = (ki == 0) ? 1 : 3;
        e.ack   = CH'(1 << ch);
        e.rdata = rd;
        if (ki == 0) exp_q0.push_back(e);
        else         exp_q1.push_back(e);
        we[ki][ch]              = w;
        addr[ki][ch*AW +: AW]   = a;
        wdata[ki][ch*DW +: DW]  = d;
        be[ki][ch*BEW +: BEW]   = b;
        req[ki][ch]             = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 12 && !seen; cyc++) begin
            @(posedge MCLK);
            @(negedge MCLK);
            if (cyc == 0) begin
                checkOutput("ram_wren", 32'(ram_wren[ki]), 32'(w & (|b)));
                checkOutput("ram_addr", 32'(ram_addr[ki]), 32'(a));
                checkOutput("ram_data", 32'(ram_data[ki]), 32'(d));
                checkOutput("ram_byteena", 32'(ram_be[ki]), 32'(b));
            end
            if (cyc == 1) checkOutput("ram_wren_one_cycle", 32'(ram_wren[ki]), 32'd0);
            if (ack[ki] != '0) begin
                seen = 1'b1;
                checkOutput("ack_latency", 32'(cyc), 32'(lat + 1));
            end
        end
        if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
        @(posedge MCLK);
        #1;
        req[ki][ch] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 0, 1'b1, 15'h0123, 16'hBEEF, 2'b11, 16'h0000};
        vecs[1] = '{0, 1, 1'b0, 15'h0123, 16'h0000, 2'b11, 16'hBEEF};
        vecs[2] = '{0, 0, 1'b1, 15'h0123, 16'h12AB, 2'b01, 16'hBEEF};
        vecs[3] = '{0, 1, 1'b0, 15'h0123, 16'h0000, 2'b11, 16'hBEAB};
        vecs[4] = '{0, 1, 1'b1, 15'h0123, 16'h5555, 2'b00, 16'hBEAB};
        vecs[5] = '{0, 2, 1'b1, 15'h0040, 16'hA5C3, 2'b10, 16'hBEAB};
        vecs[6] = '{0, 0, 1'b0, 15'h0123, 16'h0000, 2'b11, 16'hBEAB};
        vecs[7] = '{0, 2, 1'b0, 15'h0040, 16'h0000, 2'b11, 16'hA500};
        vecs[8] = '{1, 2, 1'b1, 15'h0007, 16'h1234, 2'b11, 16'h0000};
        vecs[9] = '{1, 1, 1'b0, 15'h0007, 16'h0000, 2'b11, 16'h1234};

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = '0; we[i] = '0;
            addr[i] = '0; wdata[i] = '0; be[i] = '0;
        end
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_ack", 32'(ack[i]), 32'd0);
            checkOutput("reset_rdata", 32'(rdata[i]), 32'd0);
            checkOutput("reset_ram_wren", 32'(ram_wren[i]), 32'd0);
            checkOutput("reset_ram_addr", 32'(ram_addr[i]), 32'd0);
        end
        @(posedge MCLK);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int i = 0; i < 10; i++)
            applyStimulus(vecs[i].k, vecs[i].ch, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, vecs[i].rd);

        // Round-robin, all three channels requesting continuously
        we[0] = 3'b111; be[0] = 6'b111111;
        addr[0] = {15'h0102, 15'h0101, 15'h0100};
        wdata[0] = {16'h3333, 16'h2222, 16'h1111};
        for (int r = 0; r < 6; r++) exp_q0.push_back('{CH'(1 << (r % 3)), 16'hA500});
        req[0] = 3'b111;
        cnt = 0;
        for (int cyc = 0; cyc < 80 && cnt < 6; cyc++) begin
            @(negedge MCLK);
            if (ack[0] != '0) cnt++;
        end
        @(posedge MCLK);
        #1;
        req[0] = '0;
        checkOutput("rr_ack_count", 32'(cnt), 32'd6);

        // Fixed priority: channel 0 monopolises until it drops req
        we[1] = 3'b111; be[1] = 6'b111111;
        addr[1] = {15'h0202, 15'h0201, 15'h0200};
        for (int r = 0; r < 3; r++) exp_q1.push_back('{3'b001, 16'h1234});
        exp_q1.push_back('{3'b010, 16'h1234});
        req[1] = 3'b111;
        cnt = 0;
        for (int cyc = 0; cyc < 100 && cnt < 4; cyc++) begin
            @(negedge MCLK);
            if (ack[1] != '0) begin
                cnt++;
                if (cnt == 3) begin
                    @(posedge MCLK);
                    #1;
                    req[1][0] = 1'b0;
                end
            end
        end
        @(posedge MCLK);
        #1;
        req[1] = '0;
        checkOutput("fixed_ack_count", 32'(cnt), 32'd4);

        // Reset while a RD_LAT 3 read sits in WAIT
        we[1][0] = 1'b0;
        addr[1][0 +: AW] = 15'h0007;
        req[1][0] = 1'b1;
        @(posedge MCLK);
        @(posedge MCLK);
        #1;
        rst[1] = 1'b1;
        req[1][0] = 1'b0;
        @(posedge MCLK);
        #1;
        rst[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge MCLK);
            checkOutput("abort_no_ack", 32'(ack[1]), 32'd0);
            checkOutput("abort_no_wren", 32'(ram_wren[1]), 32'd0);
            if (i == 0) begin
                checkOutput("abort_rdata", 32'(rdata[1]), 32'd0);
                checkOutput("abort_ram_addr", 32'(ram_addr[1]), 32'd0);
            end
        end

        // Round-robin pointer returns to channel 0 after reset
        @(posedge MCLK);
        #1;
        applyStimulus(0, 0, 1'b0, 15'h0123, 16'h0000, 2'b11, 16'hBEAB);
        rst[0] = 1'b1;
        @(posedge MCLK);
        #1;
        rst[0] = 1'b0;
        we[0] = 3'b000;
        addr[0] = {15'h0000, 15'h0040, 15'h0123};
        exp_q0.push_back('{3'b001, 16'hBEAB});
        exp_q0.push_back('{3'b010, 16'hA500});
        req[0] = 3'b011;
        @(negedge MCLK);
        checkOutput("rr_reset_rdata", 32'(rdata[0]), 32'd0);
        cnt = 0;
        for (int cyc = 0; cyc < 40 && cnt < 2; cyc++) begin
            @(negedge MCLK);
            if (ack[0] != '0) begin
                cnt++;
                @(posedge MCLK);
                #1;
                if (cnt == 1) req[0][0] = 1'b0;
                else          req[0][1] = 1'b0;
            end
        end
        checkOutput("rr_restart_count", 32'(cnt), 32'd2);
        checkOutput("queue0_drained", 32'(exp_q0.size()), 32'd0);
        checkOutput("queue1_drained", 32'(exp_q1.size()), 32'd0);

        repeat (3) @(posedge MCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
